// File: rtl/serial_add_sub_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_sub_if : start/busy/done operand and result bundle.  Rev 1.0
// ---------------------------------------------------------------------------
interface serial_add_sub_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_sub : bit-serial add/subtract, one bit per clock, LSB first.  Rev 1.0
// ---------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_sub_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, result_q, result_d;
  logic             c_q, c_d, mode_q, mode_d, carry_q, carry_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, last_step, sum_bit, carry_bit;
  logic             busy, done;

  assign accept    = bus.start && (state_q != S_RUN);
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign sum_bit   = sa_q[0] ^ sb_q[0] ^ c_q;
  assign carry_bit = (sa_q[0] & sb_q[0]) | (sb_q[0] & c_q) | (c_q & sa_q[0]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_step ? S_DONE : S_RUN;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (accept) begin
      // Subtract is a + ~b + 1: invert B and preload the carry with 1.
      sa_d   = bus.a;
      sb_d   = bus.mode ? ~bus.b : bus.b;
      c_d    = bus.mode;
      cnt_d  = '0;
      mode_d = bus.mode;
    end else if (state_q == S_RUN) begin
      sa_d  = {1'b0, sa_q[WIDTH-1:1]};
      sb_d  = {1'b0, sb_q[WIDTH-1:1]};
      sr_d  = {sum_bit, sr_q[WIDTH-1:1]};
      c_d   = carry_bit;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) begin
        // c_q here is the carry into the MSB, so the overflow needs no extra flop.
        result_d = {sum_bit, sr_q[WIDTH-1:1]};
        carry_d  = mode_q ? ~carry_bit : carry_bit;
        ovf_d    = c_q ^ carry_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_add_sub : scoreboard bench for serial_add_sub at WIDTH 8, 2 and 32.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_add_sub;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_v, b_v;
  logic        mode_v;
  logic [2:0]  start_v;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(8))  if8 ();
  serial_add_sub_if #(.WIDTH(2))  if2 ();
  serial_add_sub_if #(.WIDTH(32)) if32 ();

  assign if8.start  = start_v[0];
  assign if8.mode   = mode_v;
  assign if8.a      = a_v[7:0];
  assign if8.b      = b_v[7:0];
  assign if2.start  = start_v[1];
  assign if2.mode   = mode_v;
  assign if2.a      = a_v[1:0];
  assign if2.b      = b_v[1:0];
  assign if32.start = start_v[2];
  assign if32.mode  = mode_v;
  assign if32.a     = a_v;
  assign if32.b     = b_v;

  serial_add_sub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_add_sub #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(if2.slave));
  serial_add_sub #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  logic [31:0] res [3];
  logic [2:0]  busy_w, done_w, cy_w, ov_w;
  assign res[0] = 32'(if8.result);
  assign res[1] = 32'(if2.result);
  assign res[2] = if32.result;
  assign busy_w = {if32.busy, if2.busy, if8.busy};
  assign done_w = {if32.done, if2.done, if8.done};
  assign cy_w   = {if32.carry_out, if2.carry_out, if8.carry_out};
  assign ov_w   = {if32.overflow, if2.overflow, if8.overflow};

  typedef struct {
    int          k;
    logic [31:0] res;
    logic        cy;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int k);
    case (k)
      0:       return 8;
      1:       return 2;
      default: return 32;
    endcase
  endfunction

  // Reference arithmetic done in 64 bits, independent of the serial datapath.
  function automatic exp_t model(input int k, input logic m, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          w;
    logic [63:0] mask, aa, bb, r;
    logic        sa, sbb, sr;
    w    = width_of(k);
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, b} & mask;
    r    = m ? (aa - bb) : (aa + bb);
    sa   = aa[w-1];
    sbb  = bb[w-1];
    sr   = r[w-1];
    e.k   = k;
    e.res = 32'(r & mask);
    e.cy  = m ? (aa < bb) : r[w];
    e.ov  = m ? ((sa != sbb) && (sr != sa)) : ((sa == sbb) && (sr != sa));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    check_val("busy_done_excl", 32'(busy_w & done_w), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (done_w[k]) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("done_dut", 32'(k), 32'(e.k));
          check_val("result", res[k], e.res);
          check_val("carry_out", 32'(cy_w[k]), 32'(e.cy));
          check_val("overflow", 32'(ov_w[k]), 32'(e.ov));
        end
      end
    end
  end

  task automatic run_op(input int k, input logic m, input logic [31:0] a, input logic [31:0] b, input bit disturb);
    int          w, dn, lat;
    logic [31:0] prev;
    w    = width_of(k);
    dn   = (w > 3) ? 3 : w - 1;
    lat  = 0;
    @(posedge clk); #1;
    prev = res[k];
    a_v = a; b_v = b; mode_v = m; start_v[k] = 1'b1;
    sb_q.push_back(model(k, m, a, b));
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    @(negedge clk);
    check_val("busy_after_start", 32'(busy_w[k]), 32'd1);
    for (int i = 1; i <= w + 4; i++) begin
      @(posedge clk); #1;
      if (disturb && i == dn) begin
        a_v = ~a; b_v = ~b; mode_v = ~m; start_v[k] = 1'b1;
      end
      if (disturb && i == dn + 1) start_v[k] = 1'b0;
      @(negedge clk);
      if (done_w[k]) begin
        lat = i;
        break;
      end
      check_val("busy_in_run", 32'(busy_w[k]), 32'd1);
      check_val("result_hold", res[k], prev);
    end
    start_v[k] = 1'b0;
    check_val("latency", 32'(lat), 32'(w));
    @(negedge clk);
    check_val("done_pulse", 32'(done_w[k]), 32'd0);
  endtask

  task automatic reset_abort(input int k);
    int w, rn;
    w  = width_of(k);
    rn = (w > 4) ? 4 : 1;
    @(posedge clk); #1;
    a_v = 32'h3C; b_v = 32'h0F; mode_v = 1'b0; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    repeat (rn) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 32'(busy_w[k]), 32'd0);
    check_val("rst_done", 32'(done_w[k]), 32'd0);
    check_val("rst_result", res[k], 32'd0);
    check_val("rst_carry", 32'(cy_w[k]), 32'd0);
    check_val("rst_ovf", 32'(ov_w[k]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("rst_no_done", 32'(done_w[k]), 32'd0);
    end
  endtask

  task automatic b2b(input int k);
    int w, lat1, gap;
    w    = width_of(k);
    lat1 = 0;
    gap  = 0;
    @(posedge clk); #1;
    a_v = 32'h10; b_v = 32'h20; mode_v = 1'b0; start_v[k] = 1'b1;
    sb_q.push_back(model(k, 1'b0, 32'h10, 32'h20));
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    for (int i = 1; i <= w + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_w[k]) begin
        lat1 = i;
        break;
      end
    end
    check_val("b2b_first_latency", 32'(lat1), 32'(w));
    a_v = 32'h0; b_v = 32'h1; mode_v = 1'b1; start_v[k] = 1'b1;
    sb_q.push_back(model(k, 1'b1, 32'h0, 32'h1));
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    for (int j = 1; j <= w + 4; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_w[k]) begin
        gap = j + 1;
        break;
      end
    end
    check_val("b2b_gap", 32'(gap), 32'(w + 1));
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start_v = '0; a_v = '0; b_v = '0; mode_v = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val("reset_busy", 32'(busy_w[k]), 32'd0);
      check_val("reset_done", 32'(done_w[k]), 32'd0);
      check_val("reset_result", res[k], 32'd0);
      check_val("reset_carry", 32'(cy_w[k]), 32'd0);
      check_val("reset_ovf", 32'(ov_w[k]), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      run_op(k, 1'b0, 32'h3C, 32'h0F, 1'b0);
      run_op(k, 1'b0, 32'hFF, 32'h01, 1'b0);
      run_op(k, 1'b0, 32'h7F, 32'h01, 1'b0);
      run_op(k, 1'b1, 32'h05, 32'h07, 1'b0);
      run_op(k, 1'b0, 32'h3C, 32'h0F, 1'b1);
      if (k == 2) begin
        run_op(k, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0);
        run_op(k, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0);
        run_op(k, 1'b1, 32'h80000000, 32'h1, 1'b0);
      end
      repeat (4) run_op(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
      run_op(k, 1'b1, 32'h80, 32'h01, 1'b0);
      reset_abort(k);
      b2b(k);
    end
    repeat (3) @(negedge clk);
    check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial, parametrised adder/subtractor built around a single full-adder/full-subtractor cell and a carry/borrow flip-flop. It processes one operand bit per clock, LSB first, and produces a WIDTH-bit result with carry/borrow and signed-overflow flags. A start/busy/done handshake frames each operation. It is the area-lean arithmetic unit for the day-series datapath blocks that need wide add/sub without a wide ripple chain.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset; one clock; sampled only on rising edge of clk.
- start  in  1  request; accepted when busy=0.
- mode  in  1  0 = add (a+b), 1 = subtract (a−b); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  last completed result, held until the next completion.
- carry_out  out  1  add: carry out of MSB; sub: borrow (1 when a<b unsigned).
- overflow  out  1  two's-complement signed overflow of last operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start=1 -> RUN.
  - Latch a into shift register SA.
  - Latch b into SB, inverted when mode=1.
  - Load carry flip-flop c with mode (add: 0, sub: 1, i.e. a + ~b + 1).
  - Clear bit counter; latch mode.
- RUN, each cycle:
  - s = SA[0]^SB[0]^c.
  - c_next = (SA[0]&SB[0]) | (SB[0]&c) | (c&SA[0]).
  - s shifts into the MSB of internal register SR; SA and SB shift right.
  - Counter increments.
  - On the bit WIDTH−1 step, the carry into the MSB (c before update) is captured as c_msb.
- RUN, counter reaches WIDTH−1 step -> DONE. On that edge:
  - result <= final SR.
  - carry_out <= mode ? ~c_next : c_next.
  - overflow <= c_msb ^ c_next.
- DONE lasts one cycle. It returns to IDLE unless start=1, which goes straight to RUN.
- start while busy=1 is ignored. Changes on a, b or mode during RUN have no effect.
- result, carry_out and overflow never change during RUN. They update only at the RUN->DONE edge.
- Counter width is $clog2(WIDTH)+1. No arithmetic is wider than 1 bit plus carry.

## Timing
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0.
  - result = 0, carry_out = 0, overflow = 0.
  - internal SA, SB, SR, c, counter = 0.
- Reset mid-RUN aborts the operation. The next cycle shows IDLE with all reset values, and no done pulse is generated. rst has priority over start.
- Latency: start is sampled at edge E0.
  - busy = 1 after E0 through edge E(WIDTH).
  - done = 1 and outputs update after E(WIDTH); busy = 0 in that cycle.
  - done = 0 after E(WIDTH+1), unless a new start was taken at E(WIDTH+1), in which case busy = 1.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts.
- busy and done are never high in the same cycle.

## Test plan
- WIDTH=8, add 0x3C+0x0F -> result 0x4B, carry_out 0, overflow 0. done rises exactly 8 edges after the start edge, for one cycle.
- Add 0xFF+0x01 -> 0x00, carry_out 1, overflow 0. Add 0x7F+0x01 -> 0x80, carry_out 0, overflow 1.
- Sub 0x05−0x07 -> 0xFE, carry_out (borrow) 1, overflow 0. Sub 0x80−0x01 -> 0x7F, borrow 0, overflow 1.
- Start 0x3C+0x0F, then at RUN cycle 3:
  - pulse start with different operands -> ignored; result still 0x4B at done.
  - change a, b during RUN -> no effect.
  - result holds the prior value until done.
- Start an op, assert rst at RUN cycle 4:
  - next cycle busy=0, result=0, flags=0.
  - no done pulse in the following 10 cycles.
- Back-to-back: assert start during DONE of 0x10+0x20 with sub 0x00−0x01:
  - first done shows 0x30.
  - second done shows 0xFF with borrow 1, 9 edges later.
  - repeat the suite at WIDTH=2 and WIDTH=32, including 0xFFFFFFFF+1 -> 0, carry 1.
